// File: rtl/int_pc_pkg.sv
// ---------------------------------------------------------------------------
// int_pc_pkg
// Shared definitions for the interrupt PC-sequencing controller.
//   state_t         : controller FSM states
//   PCSEL_*         : encodings of the next-PC mux select
//   vector_addr()   : handler address for a source id, wraps mod 2^32
// ---------------------------------------------------------------------------
package int_pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_VEC = 2'b01;
    localparam logic [1:0] PCSEL_EPC = 2'b10;

    // 32-bit add drops the carry, so vectors near the top of memory wrap to 0.
    function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                                input logic [31:0] id,
                                                input int unsigned stride_log2);
        return base + (id << stride_log2);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// ---------------------------------------------------------------------------
// int_prio_enc
// Lowest-index-wins priority encoder.
//   req   in  N     request vector
//   valid out 1     at least one request set
//   id    out ID_W  index of the lowest set request (0 when none)
// ---------------------------------------------------------------------------
module int_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_pc_ctrl.sv
// ---------------------------------------------------------------------------
// int_pc_ctrl
// Interrupt sequencing controller for the PC stage. Captures rising edges on
// the interrupt lines, masks them, accepts one at an instruction boundary and
// redirects the PC to a vectored handler; RFE redirects back to the saved EPC.
// No nesting: one interrupt in service at a time.
//
// Ports
//   clk         in   1        clock, rising edge
//   reset       in   1        asynchronous, active-low reset
//   irq_in      in   NUM_SRC  interrupt lines, rising edge = request
//   mask_we     in   1        enable-mask write strobe
//   mask_wdata  in   NUM_SRC  new enable mask (1 = enabled)
//   commit      in   1        instruction retires this cycle
//   rfe         in   1        retiring instruction is RFE (needs commit)
//   pc_next     in   32       sequential next PC
//   pc_sel      out  2        00 sequential, 01 vector, 10 EPC
//   pc_target   out  32       redirect address, 0 when pc_sel == 00
//   epc         out  32       saved return PC
//   cause       out  log2(N)  source in service
//   in_service  out  1        high in TAKE and SERVICE
//   dbg_state   out  2        current FSM state (state_t encoding)
//
// Handshake: there is no valid/ready pair. commit is a one-cycle strobe that
// marks an instruction boundary; a redirect is presented for exactly one
// cycle (pc_sel != 00) and the datapath is expected to follow it.
// ---------------------------------------------------------------------------
module int_pc_ctrl
    import int_pc_pkg::*;
#(
    parameter int          NUM_SRC     = 4,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_1000,
    parameter int          STRIDE_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         irq_in,
    input  logic                       mask_we,
    input  logic [NUM_SRC-1:0]         mask_wdata,
    input  logic                       commit,
    input  logic                       rfe,
    input  logic [31:0]                pc_next,
    output logic [1:0]                 pc_sel,
    output logic [31:0]                pc_target,
    output logic [31:0]                epc,
    output logic [$clog2(NUM_SRC)-1:0] cause,
    output logic                       in_service,
    output logic [1:0]                 dbg_state
);

    localparam int ID_W = $clog2(NUM_SRC);

    state_t             state_q,      state_d;
    logic [NUM_SRC-1:0] irq_prev_q,   irq_prev_d;
    logic [NUM_SRC-1:0] pending_q,    pending_d;
    logic [NUM_SRC-1:0] mask_q,       mask_d;
    logic [31:0]        epc_q,        epc_d;
    logic [ID_W-1:0]    cause_q,      cause_d;
    logic [1:0]         pc_sel_q,     pc_sel_d;
    logic [31:0]        pc_target_q,  pc_target_d;
    logic               in_service_q, in_service_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;

    assign eligible = pending_q & mask_q;

    int_prio_enc #(
        .N    (NUM_SRC),
        .ID_W (ID_W)
    ) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    always_comb begin
        irq_prev_d = irq_in;
        rise       = irq_in & ~irq_prev_q;
        mask_d     = mask_we ? mask_wdata : mask_q;

        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        clr     = '0;

        case (state_q)
            ST_IDLE: begin
                // rfe has no meaning here; only commit + eligible matters.
                if (commit && win_valid) begin
                    epc_d   = pc_next;
                    cause_d = win_id;
                    clr     = NUM_SRC'(1) << win_id;
                    state_d = ST_TAKE;
                end
            end
            ST_TAKE:    state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (commit && rfe) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // A new edge on the source being accepted survives the clear.
        pending_d = (pending_q & ~clr) | rise;

        // Outputs are decoded from the next state so they are registered and
        // line up with the state they describe.
        pc_sel_d     = PCSEL_SEQ;
        pc_target_d  = '0;
        in_service_d = 1'b0;
        case (state_d)
            ST_TAKE: begin
                pc_sel_d     = PCSEL_VEC;
                pc_target_d  = vector_addr(VECTOR_BASE, 32'(cause_d), STRIDE_LOG2);
                in_service_d = 1'b1;
            end
            ST_SERVICE: begin
                in_service_d = 1'b1;
            end
            ST_RETURN: begin
                pc_sel_d    = PCSEL_EPC;
                pc_target_d = epc_q;
            end
            default: begin
                pc_sel_d = PCSEL_SEQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            epc_q        <= '0;
            cause_q      <= '0;
            pc_sel_q     <= PCSEL_SEQ;
            pc_target_q  <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_prev_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            pc_sel_q     <= pc_sel_d;
            pc_target_q  <= pc_target_d;
            in_service_q <= in_service_d;
        end
    end

    assign pc_sel     = pc_sel_q;
    assign pc_target  = pc_target_q;
    assign epc        = epc_q;
    assign cause      = cause_q;
    assign in_service = in_service_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_int_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_pc_ctrl
// Directed bench for int_pc_ctrl. Two instances: the default configuration
// and one with VECTOR_BASE near the top of memory to exercise address wrap.
// Expected redirects (with the cycle they must appear in) are queued by the
// stimulus; per-instance monitors pop and compare whenever pc_sel != 00.
// ---------------------------------------------------------------------------
module tb_int_pc_ctrl;
    import int_pc_pkg::*;

    localparam int W = 85;  // {cycle[15:0], pc_sel, pc_target, epc, cause, in_service}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0 (default parameters) ----------------
    logic [3:0]  irq_in, mask_wdata;
    logic        mask_we, commit, rfe;
    logic [31:0] pc_next;
    logic [1:0]  pc_sel, cause, dbg_state;
    logic [31:0] pc_target, epc;
    logic        in_service;

    int_pc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .commit     (commit),
        .rfe        (rfe),
        .pc_next    (pc_next),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .epc        (epc),
        .cause      (cause),
        .in_service (in_service),
        .dbg_state  (dbg_state)
    );

    // ---------------- DUT 1 (wrapping vector base) ----------------
    logic [3:0]  irq_w, mask_wdata_w;
    logic        mask_we_w, commit_w, rfe_w;
    logic [31:0] pc_next_w;
    logic [1:0]  pc_sel_w, cause_w, dbg_state_w;
    logic [31:0] pc_target_w, epc_w;
    logic        in_service_w;

    int_pc_ctrl #(
        .NUM_SRC     (4),
        .VECTOR_BASE (32'hFFFF_FFF0),
        .STRIDE_LOG2 (4)
    ) dut_w (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_w),
        .mask_we    (mask_we_w),
        .mask_wdata (mask_wdata_w),
        .commit     (commit_w),
        .rfe        (rfe_w),
        .pc_next    (pc_next_w),
        .pc_sel     (pc_sel_w),
        .pc_target  (pc_target_w),
        .epc        (epc_w),
        .cause      (cause_w),
        .in_service (in_service_w),
        .dbg_state  (dbg_state_w)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q_w[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [W-1:0] pack(input logic [15:0] c, input logic [1:0] s,
                                          input logic [31:0] t, input logic [31:0] e,
                                          input logic [1:0] ca, input logic is);
        return {c, s, t, e, ca, is};
    endfunction

    task automatic push(input int c, input logic [1:0] s, input logic [31:0] t,
                        input logic [31:0] e, input logic [1:0] ca, input logic is);
        exp_q.push_back(pack(16'(c), s, t, e, ca, is));
    endtask

    task automatic push_w(input int c, input logic [1:0] s, input logic [31:0] t,
                          input logic [31:0] e, input logic [1:0] ca, input logic is);
        exp_q_w.push_back(pack(16'(c), s, t, e, ca, is));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        if (reset) begin
            if (pc_sel != PCSEL_SEQ) begin
                n_tests++;
                act = pack(cyc[15:0], pc_sel, pc_target, epc, cause, in_service);
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_redirect: got %h expected none", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL redirect: got %h expected %h", act, exp);
                    end
                end
            end else begin
                chk("seq_target_zero", pc_target, 32'h0);
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        if (reset && pc_sel_w != PCSEL_SEQ) begin
            n_tests++;
            act = pack(cyc[15:0], pc_sel_w, pc_target_w, epc_w, cause_w, in_service_w);
            if (exp_q_w.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_redirect_w: got %h expected none", act);
            end else begin
                exp = exp_q_w.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL redirect_w: got %h expected %h", act, exp);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_sel"},     32'(pc_sel),     32'h0);
        chk({tag, "_pc_target"},  pc_target,       32'h0);
        chk({tag, "_epc"},        epc,             32'h0);
        chk({tag, "_cause"},      32'(cause),      32'h0);
        chk({tag, "_in_service"}, 32'(in_service), 32'h0);
        chk({tag, "_state"},      32'(dbg_state),  32'(ST_IDLE));
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int k, r, m;
        reset = 1'b0;
        irq_in = '0; mask_we = 1'b0; mask_wdata = '0; commit = 1'b0; rfe = 1'b0; pc_next = '0;
        irq_w = '0; mask_we_w = 1'b0; mask_wdata_w = '0; commit_w = 1'b0; rfe_w = 1'b0; pc_next_w = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        step();
        reset = 1'b1;
        step();
        chk("idle_after_por", 32'(dbg_state), 32'(ST_IDLE));

        // Basic take: source 2, vector 0x1020
        mask_we = 1'b1; mask_wdata = 4'hF;
        step();
        mask_we = 1'b0;
        irq_in = 4'b0100; commit = 1'b1; pc_next = 32'h100;
        k = cyc;
        push(k + 2, PCSEL_VEC, 32'h1020, 32'h100, 2'd2, 1'b1);
        step(); step(); step();
        chk("basic_service", 32'(dbg_state), 32'(ST_SERVICE));
        rfe = 1'b1; r = cyc;
        push(r + 1, PCSEL_EPC, 32'h100, 32'h100, 2'd2, 1'b0);
        step();
        rfe = 1'b0;
        chk("basic_return", 32'(dbg_state), 32'(ST_RETURN));
        step();
        chk("basic_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Priority / no nesting: 1 and 3 together, 1 first, 3 after one IDLE cycle
        irq_in = 4'b1010; pc_next = 32'h200;
        k = cyc;
        push(k + 2, PCSEL_VEC, 32'h1010, 32'h200, 2'd1, 1'b1);
        step(); step(); step(); step();
        chk("prio_no_nest", 32'(dbg_state), 32'(ST_SERVICE));
        rfe = 1'b1; r = cyc;
        push(r + 1, PCSEL_EPC, 32'h200, 32'h200, 2'd1, 1'b0);
        step();
        rfe = 1'b0; pc_next = 32'h300;
        push(r + 3, PCSEL_VEC, 32'h1030, 32'h300, 2'd3, 1'b1);
        step();
        chk("prio_dwell_idle", 32'(dbg_state), 32'(ST_IDLE));
        step();
        chk("prio_take3", 32'(dbg_state), 32'(ST_TAKE));
        step();
        rfe = 1'b1; r = cyc;
        push(r + 1, PCSEL_EPC, 32'h300, 32'h300, 2'd3, 1'b0);
        step();
        rfe = 1'b0;
        step();

        // Mask hold: masked source stays pending, taken two cycles after unmask
        irq_in = 4'b0000; mask_we = 1'b1; mask_wdata = 4'h0;
        step();
        mask_we = 1'b0; irq_in = 4'b0001; pc_next = 32'h400;
        step(); step(); step(); step();
        chk("mask_hold_idle", 32'(dbg_state), 32'(ST_IDLE));
        mask_we = 1'b1; mask_wdata = 4'b0001; m = cyc;
        push(m + 2, PCSEL_VEC, 32'h1000, 32'h400, 2'd0, 1'b1);
        step();
        mask_we = 1'b0;
        step(); step();
        rfe = 1'b1; r = cyc;
        push(r + 1, PCSEL_EPC, 32'h400, 32'h400, 2'd0, 1'b0);
        step();
        rfe = 1'b0;
        step();

        // RFE qualification: ignored in IDLE, needs commit in SERVICE
        rfe = 1'b1;
        step(); step(); step();
        chk("rfe_idle_ignored", 32'(dbg_state), 32'(ST_IDLE));
        rfe = 1'b0;
        mask_we = 1'b1; mask_wdata = 4'hF; irq_in = 4'b0100; pc_next = 32'h500;
        k = cyc;
        push(k + 2, PCSEL_VEC, 32'h1020, 32'h500, 2'd2, 1'b1);
        step();
        mask_we = 1'b0;
        step(); step();
        commit = 1'b0; rfe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rfe_no_commit_service", 32'(dbg_state), 32'(ST_SERVICE));
        end
        commit = 1'b1; r = cyc;
        push(r + 1, PCSEL_EPC, 32'h500, 32'h500, 2'd2, 1'b0);
        step();
        chk("rfe_commit_return", 32'(dbg_state), 32'(ST_RETURN));
        rfe = 1'b0;
        step();
        chk("rfe_back_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Reset during SERVICE with another request pending
        irq_in = 4'b0000;
        step();
        irq_in = 4'b0001; pc_next = 32'h600;
        k = cyc;
        push(k + 2, PCSEL_VEC, 32'h1000, 32'h600, 2'd0, 1'b1);
        step(); step(); step();
        irq_in = 4'b1001;
        step();
        chk("pre_reset_service", 32'(dbg_state), 32'(ST_SERVICE));
        #2;
        reset = 1'b0; irq_in = 4'b0000;
        #1;
        chk_reset_outputs("mid");
        step();
        chk_reset_outputs("mid_hold");
        reset = 1'b1;
        mask_we = 1'b1; mask_wdata = 4'hF;
        step();
        mask_we = 1'b0;
        step(); step(); step();
        chk("pending_lost_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Vector address wrap on the second instance: 0xFFFF_FFF0 + 0x10 -> 0
        mask_we_w = 1'b1; mask_wdata_w = 4'b0010;
        step();
        mask_we_w = 1'b0; irq_w = 4'b0010; commit_w = 1'b1; pc_next_w = 32'h700;
        k = cyc;
        push_w(k + 2, PCSEL_VEC, 32'h0000_0000, 32'h700, 2'd1, 1'b1);
        step(); step(); step();
        rfe_w = 1'b1; r = cyc;
        push_w(r + 1, PCSEL_EPC, 32'h700, 32'h700, 2'd1, 1'b0);
        step();
        rfe_w = 1'b0;
        step(); step(); step();

        chk("exp_q_drained",   32'(exp_q.size()),   32'h0);
        chk("exp_q_w_drained", 32'(exp_q_w.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
